// File: rtl/instr_encoder_if.sv
// instr_encoder_if: host-side instruction beat stream plus instruction-memory
// write port of the RV32I instruction encoder / program loader.
//   start            one-cycle pulse that opens a new load session
//   in_valid/in_ready  beat handshake; in_kind, in_rd, in_rs1, in_rs2,
//                    in_imm, in_last describe one symbolic instruction
//   mem_we/mem_ready write handshake; mem_addr, mem_wdata carry the word
//   count/done/err   session status
// Modports: slave = encoder side, master = host/memory side.
interface instr_encoder_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  start;
  logic                  in_valid;
  logic                  in_ready;
  logic [4:0]            in_kind;
  logic [4:0]            in_rd;
  logic [4:0]            in_rs1;
  logic [4:0]            in_rs2;
  logic [31:0]           in_imm;
  logic                  in_last;
  logic                  mem_we;
  logic [31:0]           mem_addr;
  logic [31:0]           mem_wdata;
  logic                  mem_ready;
  logic [ADDR_WIDTH:0]   count;
  logic                  done;
  logic                  err;

  modport slave (
    input  start, in_valid, in_kind, in_rd, in_rs1, in_rs2, in_imm, in_last,
           mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata, count, done, err
  );

  modport master (
    output start, in_valid, in_kind, in_rd, in_rs1, in_rs2, in_imm, in_last,
           mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata, count, done, err
  );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: streaming RV32I instruction encoder and program loader.
// Accepts one symbolic instruction per beat, packs it into a 32-bit machine
// word (illegal kinds / out-of-range immediates become a NOP and set err),
// and writes it to instruction memory at consecutive word addresses.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  instr_encoder_if.slave (beat stream, memory write port, status)
// Parameters:
//   ADDR_WIDTH  word-index width, memory depth = 2**ADDR_WIDTH words
//   BASE_ADDR   byte address of word 0
module instr_encoder #(
  parameter int          ADDR_WIDTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  instr_encoder_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_ACCEPT, S_WRITE, S_DONE} state_t;

  localparam logic [31:0]       NOP   = 32'h0000_0013;
  localparam logic [ADDR_WIDTH:0] ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] DEPTH = ONE << ADDR_WIDTH;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  function automatic logic f_fits(input logic signed [31:0] v,
                                  input logic signed [31:0] lo,
                                  input logic signed [31:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // funct3 for the ALU kinds in R-type numbering (0 ADD .. 9 SLTU).
  function automatic logic [2:0] f_alu_f3(input logic [4:0] rk);
    logic [2:0] f3;
    case (rk)
      5'd0, 5'd1: f3 = 3'b000;
      5'd2:       f3 = 3'b111;
      5'd3:       f3 = 3'b110;
      5'd4:       f3 = 3'b100;
      5'd5:       f3 = 3'b001;
      5'd6, 5'd7: f3 = 3'b101;
      5'd8:       f3 = 3'b010;
      default:    f3 = 3'b011;
    endcase
    return f3;
  endfunction

  // Returns {legal, word}; an illegal encoding always carries the NOP word.
  function automatic logic [32:0] f_encode(input logic [4:0] kind,
                                           input logic [4:0] rd,
                                           input logic [4:0] rs1,
                                           input logic [4:0] rs2,
                                           input logic signed [31:0] imm);
    logic        ok;
    logic [31:0] w;
    logic [4:0]  rk;
    logic [6:0]  f7;
    ok = 1'b1;
    w  = NOP;
    // I-arith kinds follow the R-type order with SUB removed.
    rk = (kind == 5'd10) ? 5'd0 : kind - 5'd9;
    f7 = 7'b0000000;
    case (kind)
      5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9: begin
        f7 = (kind == 5'd1 || kind == 5'd7) ? 7'b0100000 : 7'b0000000;
        w  = {f7, rs2, rs1, f_alu_f3(kind), rd, OP_R};
      end
      5'd10, 5'd11, 5'd12, 5'd13, 5'd17, 5'd18: begin
        ok = f_fits(imm, -32'sd2048, 32'sd2047);
        w  = {imm[11:0], rs1, f_alu_f3(rk), rd, OP_I};
      end
      5'd14, 5'd15, 5'd16: begin
        ok = f_fits(imm, 32'sd0, 32'sd31);
        f7 = (kind == 5'd16) ? 7'b0100000 : 7'b0000000;
        w  = {f7, imm[4:0], rs1, f_alu_f3(rk), rd, OP_I};
      end
      5'd19: begin
        ok = f_fits(imm, -32'sd2048, 32'sd2047);
        w  = {imm[11:0], rs1, 3'b010, rd, OP_LD};
      end
      5'd20: begin
        ok = f_fits(imm, -32'sd2048, 32'sd2047);
        w  = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_ST};
      end
      5'd21, 5'd22: begin
        ok = f_fits(imm, -32'sd4096, 32'sd4094) && !imm[0];
        w  = {imm[12], imm[10:5], rs2, rs1, (kind == 5'd22) ? 3'b001 : 3'b000,
              imm[4:1], imm[11], OP_BR};
      end
      5'd23: begin
        ok = f_fits(imm, -32'sd1048576, 32'sd1048574) && !imm[0];
        w  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
      end
      5'd24: begin
        ok = f_fits(imm, -32'sd2048, 32'sd2047);
        w  = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
      end
      5'd25: begin
        ok = (imm[11:0] == 12'h000);
        w  = {imm[31:12], rd, OP_LUI};
      end
      default: ok = 1'b0;
    endcase
    return {ok, ok ? w : NOP};
  endfunction

  state_t              r_state;
  logic                r_in_ready;
  logic                r_mem_we;
  logic [31:0]         r_wdata;
  logic                r_last;
  logic [ADDR_WIDTH:0] r_count;
  logic                r_done;
  logic                r_err;

  logic [32:0]         w_enc;
  logic [ADDR_WIDTH:0] w_cnt_nxt;

  assign w_enc     = f_encode(bus.in_kind, bus.in_rd, bus.in_rs1, bus.in_rs2,
                              bus.in_imm);
  assign w_cnt_nxt = r_count + ONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_in_ready <= 1'b0;
      r_mem_we   <= 1'b0;
      r_wdata    <= '0;
      r_last     <= 1'b0;
      r_count    <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_state    <= S_ACCEPT;
            r_in_ready <= 1'b1;
            r_count    <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
          end
        end
        S_ACCEPT: begin
          if (bus.in_valid) begin
            r_wdata    <= w_enc[31:0];
            r_last     <= bus.in_last;
            r_in_ready <= 1'b0;
            r_mem_we   <= 1'b1;
            r_state    <= S_WRITE;
            if (!w_enc[32]) r_err <= 1'b1;
          end
        end
        S_WRITE: begin
          if (bus.mem_ready) begin
            r_count  <= w_cnt_nxt;
            r_mem_we <= 1'b0;
            if (r_last || w_cnt_nxt == DEPTH) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              // Memory full while the host still had more to send.
              if (!r_last) r_err <= 1'b1;
            end else begin
              r_state    <= S_ACCEPT;
              r_in_ready <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = BASE_ADDR + (32'(r_count) << 2);
  assign bus.mem_wdata = r_wdata;
  assign bus.count     = r_count;
  assign bus.done      = r_done;
  assign bus.err       = r_err;

endmodule
